// File: rtl/arb_pkg.sv
// arb_pkg: shared defaults, types and buffer state for the priority/age arbiter
package arb_pkg;
    localparam int N_CH   = 8;
    localparam int DATA_W = 32;
    localparam int PRIO_W = 3;
    localparam int AGE_W  = 4;
    typedef logic [$clog2(N_CH)-1:0] ch_idx_t;
    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [AGE_W-1:0] age_t;
    typedef logic [PRIO_W:0] eff_prio_t;
    typedef enum logic {EMPTY, FULL} buf_state_t;
endpackage

// File: rtl/prio_rr_pick.sv
// prio_rr_pick: highest effective priority wins, ties go to the first requester after last
module prio_rr_pick #(
    parameter int N_CH = 8,
    parameter int EW   = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH*EW-1:0]      eff,
    input  logic [$clog2(N_CH)-1:0] last,
    output logic [N_CH-1:0]         gnt,
    output logic [$clog2(N_CH)-1:0] idx
);
    localparam int IW = $clog2(N_CH);
    logic          found;
    logic [EW-1:0] best;
    // scan upward from last+1 so a strict compare keeps the earliest equal requester
    always_comb begin
        int c;
        c = 0;
        found = 1'b0;
        best = '0;
        idx = '0;
        for (int k = 1; k <= N_CH; k++) begin
            c = (int'(last) + k) % N_CH;
            if (req[c] && (!found || eff[c*EW +: EW] > best)) begin
                found = 1'b1;
                best = eff[c*EW +: EW];
                idx = IW'(c);
            end
        end
        gnt = found ? {{(N_CH-1){1'b0}}, 1'b1} << idx : '0;
    end
endmodule

// File: rtl/prio_age_arbiter.sv
// prio_age_arbiter: N-channel priority arbiter with round-robin ties, aging and a one-word output buffer
module prio_age_arbiter #(
    parameter int N_CH   = arb_pkg::N_CH,
    parameter int DATA_W = arb_pkg::DATA_W,
    parameter int PRIO_W = arb_pkg::PRIO_W,
    parameter int AGE_W  = arb_pkg::AGE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          valid_i,
    input  logic [N_CH*DATA_W-1:0]   data_i,
    input  logic [N_CH*PRIO_W-1:0]   prioity_i,
    output logic [N_CH-1:0]          ready_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    input  logic                     ready_o,
    output logic [$clog2(N_CH)-1:0]  grant_ch_o
);
    import arb_pkg::*;
    localparam int IW = $clog2(N_CH);
    localparam int EW = PRIO_W + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    buf_state_t           state;
    logic [AGE_W-1:0]     age [N_CH];
    logic [IW-1:0]        last_grant;
    logic [IW-1:0]        win;
    logic [N_CH*EW-1:0]   eff;
    logic [N_CH-1:0]      gnt;
    logic                 slot;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_eff
            assign eff[g*EW +: EW] = {age[g] == AGE_MAX, prioity_i[g*PRIO_W +: PRIO_W]};
        end
    endgenerate

    prio_rr_pick #(.N_CH(N_CH), .EW(EW)) u_pick (
        .req  (valid_i),
        .eff  (eff),
        .last (last_grant),
        .gnt  (gnt),
        .idx  (win)
    );

    assign slot    = (state == EMPTY) || ready_o;
    assign ready_i = (slot && !reset) ? gnt : '0;
    assign valid_o = (state == FULL);

    // buffer FSM, winner capture and age bookkeeping, all advancing only in accept slots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            data_o     <= '0;
            grant_ch_o <= '0;
            last_grant <= IW'(N_CH - 1);
            for (int i = 0; i < N_CH; i++) age[i] <= '0;
        end else if (slot) begin
            if (|valid_i) begin
                state      <= FULL;
                data_o     <= data_i[int'(win)*DATA_W +: DATA_W];
                grant_ch_o <= win;
                last_grant <= win;
                for (int i = 0; i < N_CH; i++)
                    age[i] <= (!valid_i[i] || gnt[i]) ? '0 : (age[i] == AGE_MAX ? age[i] : age[i] + 1'b1);
            end else begin
                state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_prio_age_arbiter.sv
// tb_prio_age_arbiter: vector table plus scoreboard for the arbiter, second instance with AGE_W=2 for aging
module tb_prio_age_arbiter;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    valid_i = '0;
    logic [255:0]  data_i = '0;
    logic [23:0]   prioity_i = '0;
    logic          ready_o = 1'b0;
    logic [7:0]    ready_i, ready_i2;
    logic [31:0]   data_o, data_o2;
    logic          valid_o, valid_o2;
    logic [2:0]    grant_ch_o, grant_ch_o2;

    localparam logic [23:0] ALL4 = 24'o44444444;

    typedef struct {
        logic [7:0]  v;
        logic [23:0] pr;
        logic        r;
        logic [7:0]  e;
        logic        c2;
        logic [7:0]  e2;
    } vec_t;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] d;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    prio_age_arbiter dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .prioity_i(prioity_i),
        .ready_i(ready_i), .data_o(data_o), .valid_o(valid_o), .ready_o(ready_o), .grant_ch_o(grant_ch_o)
    );

    prio_age_arbiter #(.AGE_W(2)) dut2 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i), .prioity_i(prioity_i),
        .ready_i(ready_i2), .data_o(data_o2), .valid_o(valid_o2), .ready_o(ready_o), .grant_ch_o(grant_ch_o2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] p(input int ch, input int val);
        return 24'(val) << (3 * ch);
    endfunction

    function automatic logic [2:0] oh2i(input logic [7:0] o);
        for (int i = 0; i < 8; i++) if (o[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic vec_t mk(input logic [7:0] v, input logic [23:0] pr, input logic r,
                                input logic [7:0] e, input logic c2, input logic [7:0] e2);
        vec_t t;
        t.v = v; t.pr = pr; t.r = r; t.e = e; t.c2 = c2; t.e2 = e2;
        return t;
    endfunction

    task automatic step(input vec_t t);
        @(negedge clk);
        valid_i = t.v;
        prioity_i = t.pr;
        ready_o = t.r;
        for (int i = 0; i < 8; i++) data_i[i*32 +: 32] = {cyc[23:0], 8'(i)};
        #1;
        check($sformatf("ready_i cyc%0d", cyc), 32'(ready_i), 32'(t.e));
        if (t.c2) check($sformatf("ready_i age2 cyc%0d", cyc), 32'(ready_i2), 32'(t.e2));
        if (sb.size() == 0) begin
            check($sformatf("valid_o cyc%0d", cyc), 32'(valid_o), 32'd0);
        end else begin
            check($sformatf("valid_o cyc%0d", cyc), 32'(valid_o), 32'd1);
            check($sformatf("data_o cyc%0d", cyc), data_o, sb[0].d);
            check($sformatf("grant_ch_o cyc%0d", cyc), 32'(grant_ch_o), 32'(sb[0].ch));
            if (t.r) void'(sb.pop_front());
        end
        if (t.e != 8'h00) sb.push_back('{oh2i(t.e), {cyc[23:0], 5'd0, oh2i(t.e)}});
        cyc++;
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        valid_i = '1;
        prioity_i = '0;
        ready_o = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset valid_o age2", 32'(valid_o2), 32'd0);
        check("reset ready_i", 32'(ready_i), 32'd0);
        check("reset ready_i age2", 32'(ready_i2), 32'd0);
        check("reset data_o", data_o, 32'd0);
        check("reset grant_ch_o", 32'(grant_ch_o), 32'd0);
        sb.delete();
        @(negedge clk);
        valid_i = '0;
        #2 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 8; k++) tbl.push_back(mk(8'hFF, ALL4, 1'b1, 8'(1 << k), 1'b0, 8'h00));
        tbl.push_back(mk(8'h44, p(2, 5) | p(6, 3), 1'b1, 8'h04, 1'b0, 8'h00));
        tbl.push_back(mk(8'h00, 24'd0, 1'b1, 8'h00, 1'b0, 8'h00));
        tbl.push_back(mk(8'h00, 24'd0, 1'b1, 8'h00, 1'b0, 8'h00));
        tbl.push_back(mk(8'h30, p(4, 1) | p(5, 1), 1'b1, 8'h10, 1'b0, 8'h00));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(8'h30, p(4, 1) | p(5, 1), 1'b0, 8'h00, 1'b0, 8'h00));
        tbl.push_back(mk(8'h30, p(4, 1) | p(5, 1), 1'b1, 8'h20, 1'b0, 8'h00));
        tbl.push_back(mk(8'h10, p(4, 1), 1'b1, 8'h10, 1'b0, 8'h00));
        tbl.push_back(mk(8'h00, 24'd0, 1'b1, 8'h00, 1'b0, 8'h00));

        pulse_reset();
        foreach (tbl[i]) step(tbl[i]);

        step(mk(8'h09, p(0, 6) | p(3, 1), 1'b1, 8'h01, 1'b0, 8'h00));
        step(mk(8'h09, p(0, 6) | p(3, 1), 1'b1, 8'h01, 1'b0, 8'h00));
        pulse_reset();

        step(mk(8'h0B, p(0, 7), 1'b1, 8'h01, 1'b1, 8'h01));
        for (int k = 0; k < 5; k++) step(mk(8'h0B, p(0, 7), 1'b0, 8'h00, 1'b1, 8'h00));
        step(mk(8'h0B, p(0, 7), 1'b1, 8'h01, 1'b1, 8'h01));
        step(mk(8'h0B, p(0, 7), 1'b1, 8'h01, 1'b1, 8'h01));
        step(mk(8'h0B, p(0, 7), 1'b1, 8'h01, 1'b1, 8'h02));
        step(mk(8'h0B, p(0, 7), 1'b1, 8'h01, 1'b1, 8'h08));
        check("grant_ch_o age2 after aged win", 32'(grant_ch_o2), 32'd1);
        step(mk(8'h0B, p(0, 7), 1'b1, 8'h01, 1'b1, 8'h01));
        check("grant_ch_o age2 second aged win", 32'(grant_ch_o2), 32'd3);
        step(mk(8'h00, 24'd0, 1'b1, 8'h00, 1'b1, 8'h00));
        step(mk(8'h0B, p(0, 7), 1'b1, 8'h01, 1'b1, 8'h01));
        pulse_reset();

        step(mk(8'hFF, ALL4, 1'b1, 8'h01, 1'b1, 8'h01));
        step(mk(8'h00, 24'd0, 1'b1, 8'h00, 1'b1, 8'h00));
        step(mk(8'h00, 24'd0, 1'b1, 8'h00, 1'b1, 8'h00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/prio_age_arbiter.md
# prio_age_arbiter

Eight-channel priority arbiter with round-robin tie-break and age-based anti-starvation, feeding a single registered valid/ready output. It sits between the eight per-channel input interfaces (valid, data, prioity, ready) and the shared output interface (valid, data, ready) of the top-level datapath. It replaces ad-hoc selection with a fair, stall-safe scheduler.

## Interface
- N_CH, 8, number of requesting channels
- DATA_W, 32, payload width
- PRIO_W, 3, priority width; larger value means more urgent
- AGE_W, 4, age counter width; AGE_MAX = 2^AGE_W-1
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_i  in  N_CH  per-channel request
- data_i  in  N_CH*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W]
- prioity_i  in  N_CH*PRIO_W  per-channel priority; channel i occupies bits [i*PRIO_W +: PRIO_W]
- ready_i  out  N_CH  per-channel accept, one-hot or zero
- data_o  out  DATA_W  registered payload
- valid_o  out  1  output valid
- ready_o  in  1  downstream accept
- grant_ch_o  out  $clog2(N_CH)  channel index of the word currently in data_o

## Operation
- Output buffer: one entry with states EMPTY (valid_o=0) and FULL (valid_o=1).
- Accept slot: a cycle is an accept slot when state==EMPTY, or when state==FULL and ready_o=1.
- Effective priority per channel: {age==AGE_MAX, prioity}. An aged channel therefore outranks every non-aged channel.
- Winner: among channels with valid_i=1, the highest effective priority wins.
- Tie-break: among equal effective priorities, the first channel found scanning upward from (last_grant+1) mod N_CH, with wrap-around.
- Grant: in an accept slot with at least one valid_i, ready_i[winner]=1. All other ready_i are 0. ready_i is combinational from valid_i, prioity_i, the age counters, last_grant, state and ready_o.
- On the edge of a grant:
  - data_o ← data_i[winner]
  - grant_ch_o ← winner
  - last_grant ← winner
  - state → FULL
- Drain with no new grant: accept slot with state FULL, ready_o=1 and no valid_i → state EMPTY. data_o and grant_ch_o hold their values.
- Simultaneous drain and grant: FULL stays FULL and loads the new word. Sustained throughput is 1 word per cycle.
- Age update, applied only in accept slots that have at least one valid_i:
  - winner age ← 0
  - other requesting channels: age +1, saturating at AGE_MAX
  - channels with valid_i=0: age ← 0
- Ages hold in all other cycles, including output stall.
- Several aged channels: they tie at the top level and are resolved by the round-robin rule.
- Input contract: a requester holds valid_i, data_i and prioity_i stable until its ready_i=1. The block does not check this.
- Output contract: the block holds valid_o, data_o and grant_ch_o stable while valid_o=1 and ready_o=0.

## Timing
- Reset values:
  - valid_o=0, data_o=0, grant_ch_o=0
  - all ready_i=0 while reset is asserted
  - ages=0
  - last_grant=N_CH-1, so channel 0 wins the first tie
  - state EMPTY
- Latency: a word accepted at edge k is visible on data_o/valid_o immediately after edge k (1 cycle).
- Reset asserted mid-operation: the buffered word is discarded and all state returns to reset values asynchronously. No ready_i pulse while reset is high.
- The combinational path ready_o → ready_i is allowed. There is no path from valid_i to valid_o within a cycle.

## Structure
- Package arb_pkg holds:
  - N_CH, DATA_W, PRIO_W, AGE_W defaults
  - typedefs ch_idx_t, prio_t, age_t, eff_prio_t
  - buffer state enum {EMPTY, FULL}
- Sub-module prio_rr_pick (combinational):
  - inputs: request vector, effective priorities, last_grant
  - outputs: one-hot grant and winner index
- Age counters, last_grant, output buffer and FSM live in prio_age_arbiter.

## Test plan
- Priority: ch2 prio 5 and ch6 prio 3 valid, ready_o=1 → ready_i=0x04; data_o=data_i[2] and grant_ch_o=2 the next cycle.
- Round-robin tie: all 8 channels at prio 4, ready_o=1, held for 8 cycles → grant order 0,1,2,…,7; every channel granted exactly once.
- Starvation with AGE_W=2: ch0 prio 7 valid continuously, ch1 prio 0 valid → ch1 is granted on its 4th accept slot (age reaches 3), then ch0 resumes.
- Backpressure: ready_o=0 for 5 cycles while FULL → data_o, grant_ch_o and all ages unchanged, ready_i=0; ready_o=1 → back-to-back grants, one per cycle.
- Drain with no requests: FULL, ready_o=1, no valid_i → valid_o=0 next cycle.
- Reset mid-stream: reset pulsed while FULL and ch3 aged to 2 → valid_o=0, all ages 0, first tie after reset goes to ch0.
